// File: rtl/alu_seq_pkg.sv
// Shared types and decode helpers for the ALU sequencer.
// Opcode and FSM state encodings, plus opcode classification functions.
package alu_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    // Opcodes that need a round trip through the external ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        case (op)
            OP_ADD, OP_AND, OP_XOR: is_alu_op = 1'b1;
            default:                is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_LDI, OP_ADD, OP_AND, OP_XOR: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// Architectural register file: two operand read ports, one debug read port,
// one synchronous write port, asynchronously cleared to zero.
module seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [AW-1:0]     dbg_raddr_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] rf_q [NREGS];

    // Register storage with async clear and single write port.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o    = rf_q[raddr1_i];
    assign rdata2_o    = rf_q[raddr2_i];
    assign dbg_rdata_o = rf_q[dbg_raddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external ALU and writing
// results back into a small register file.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int NREGS = 4,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_src1,
    input  logic [AW-1:0] instr_src2,
    input  logic [7:0]    instr_imm,
    output logic [7:0]    alu_rs1,
    output logic [7:0]    alu_rs2,
    output logic [2:0]    alu_opcode,
    input  logic [7:0]    alu_rd,
    input  logic          alu_is_zero,
    output logic          done,
    output logic          err,
    output logic          zero_flag,
    input  logic [AW-1:0] dbg_raddr,
    output logic [7:0]    dbg_rdata
);

    state_e        state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] dst_q;
    logic [7:0]    imm_q;
    logic [7:0]    opa_q;
    logic [7:0]    opb_q;
    logic [7:0]    result_q;
    logic          zero_q;

    logic          rf_we_s;
    logic [7:0]    wdata_s;
    logic [7:0]    rf_rd1_s;
    logic [7:0]    rf_rd2_s;
    logic          accept_s;

    // The ALU result is written verbatim, so its zero indication is not consumed.
    logic          unused_alu_is_zero_s;
    assign unused_alu_is_zero_s = alu_is_zero;

    seq_regfile #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .we_i        (rf_we_s),
        .waddr_i     (dst_q),
        .wdata_i     (wdata_s),
        .raddr1_i    (instr_src1),
        .rdata1_o    (rf_rd1_s),
        .raddr2_i    (instr_src2),
        .rdata2_o    (rf_rd2_s),
        .dbg_raddr_i (dbg_raddr),
        .dbg_rdata_o (dbg_rdata)
    );

    assign accept_s  = (state_q == IDLE) && instr_valid;
    assign wdata_s   = (op_q == OP_LDI) ? imm_q : result_q;
    assign zero_flag = zero_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state outputs; ALU port is quiet outside EXEC.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        rf_we_s     = 1'b0;
        alu_rs1     = 8'h00;
        alu_rs2     = 8'h00;
        alu_opcode  = 3'b000;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = is_alu_op(instr_op) ? EXEC : WB;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                alu_rs1    = opa_q;
                alu_rs2    = opb_q;
                alu_opcode = op_q;
                state_d    = WB;
            end
            WB: begin
                done    = 1'b1;
                err     = ~is_legal_op(op_q);
                rf_we_s = is_legal_op(op_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction latch, operand capture, ALU result capture and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'b000;
            dst_q    <= '0;
            imm_q    <= 8'h00;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            result_q <= 8'h00;
            zero_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                op_q  <= instr_op;
                dst_q <= instr_dst;
                imm_q <= instr_imm;
                if (is_alu_op(instr_op)) begin
                    opa_q <= rf_rd1_s;
                    opb_q <= rf_rd2_s;
                end
            end
            if (state_q == EXEC) begin
                result_q <= alu_rd;
            end
            if (rf_we_s) begin
                zero_q <= (wdata_s == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions push expected
// retire records; a monitor pops them on done and checks write-back.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_dst, instr_src1, instr_src2;
    logic [7:0] instr_imm;
    logic [7:0] alu_rs1, alu_rs2, alu_rd;
    logic [2:0] alu_opcode;
    logic       alu_is_zero;
    logic       done, err, zero_flag;
    logic [1:0] dbg_raddr;
    logic [7:0] dbg_rdata;

    logic [1:0] mon_raddr = 2'd0;
    logic [1:0] tb_raddr  = 2'd0;
    logic       use_tb_raddr = 1'b0;
    logic       alu_force_zero = 1'b0;

    assign dbg_raddr = use_tb_raddr ? tb_raddr : mon_raddr;

    always #5 clk = ~clk;

    alu_sequencer #(.NREGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_dst   (instr_dst),
        .instr_src1  (instr_src1),
        .instr_src2  (instr_src2),
        .instr_imm   (instr_imm),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_opcode  (alu_opcode),
        .alu_rd      (alu_rd),
        .alu_is_zero (alu_is_zero),
        .done        (done),
        .err         (err),
        .zero_flag   (zero_flag),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    // External ALU stub, with an override that forces a zero result.
    always_comb begin
        alu_rd = 8'h00;
        if (!alu_force_zero) begin
            case (alu_opcode)
                3'b010:  alu_rd = alu_rs1 + alu_rs2;
                3'b011:  alu_rd = alu_rs1 & alu_rs2;
                3'b100:  alu_rd = alu_rs1 ^ alu_rs2;
                default: alu_rd = 8'h00;
            endcase
        end
    end
    assign alu_is_zero = (alu_rs1 == 8'h00);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       err;
        logic [1:0] dst;
        logic [7:0] val;
        logic       zf;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    bit   pend_valid = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop on done, check the write-back one cycle later.
    always @(negedge clk) begin
        exp_t item;
        if (pend_valid) begin
            chk("wb_data", {24'h0, dbg_rdata}, {24'h0, pend.val});
            chk("wb_zero_flag", {31'h0, zero_flag}, {31'h0, pend.zf});
            pend_valid = 1'b0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                item = sb.pop_front();
                chk("err", {31'h0, err}, {31'h0, item.err});
                chk("latency", cyc - item.acc + 1, item.lat);
                pend       = item;
                pend_valid = 1'b1;
                mon_raddr  = item.dst;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [7:0] imm,
                         input logic [7:0] ers1, input logic [7:0] ers2,
                         input logic exp_err, input logic [7:0] exp_val, input logic exp_zf);
        int   waited = 0;
        exp_t e;
        bit   alu_op;
        alu_op = (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        instr_op = op; instr_dst = dst; instr_src1 = s1; instr_src2 = s2; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        e.err = exp_err; e.dst = dst; e.val = exp_val; e.zf = exp_zf;
        e.lat = alu_op ? 2 : 1; e.acc = cyc;
        sb.push_back(e);
        if (alu_op) begin
            @(negedge clk);
            chk("exec_rs1", {24'h0, alu_rs1}, {24'h0, ers1});
            chk("exec_rs2", {24'h0, alu_rs2}, {24'h0, ers2});
            chk("exec_opcode", {29'h0, alu_opcode}, {29'h0, op});
            @(negedge clk);
            chk("wb_alu_quiet", {21'h0, alu_rs1, alu_opcode}, 32'd0);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || pend_valid) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb.size() + (pend_valid ? 1 : 0), 32'd0);
    endtask

    task automatic check_rf_zero(input string name);
        use_tb_raddr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tb_raddr = i[1:0];
            #1;
            chk(name, {24'h0, dbg_rdata}, 32'd0);
        end
        use_tb_raddr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   accepted;
        logic rdy;
        exp_t e;
        logic [5:0] ready_pat;
        ready_pat = 6'b100100;
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'b000;
        instr_dst = 2'd0; instr_src1 = 2'd0; instr_src2 = 2'd0; instr_imm = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", {31'h0, instr_ready}, 32'd1);
        chk("reset_done_err", {30'h0, done, err}, 32'd0);
        chk("reset_zero_flag", {31'h0, zero_flag}, 32'd0);
        chk("reset_alu_quiet", {13'h0, alu_rs1, alu_rs2, alu_opcode}, 32'd0);
        check_rf_zero("reset_rf");

        // LDI r1,5; LDI r2,3; ADD r0,r1,r2 -> 8
        issue(3'b001, 2'd1, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 1'b0, 8'h05, 1'b0);
        issue(3'b001, 2'd2, 2'd0, 2'd0, 8'h03, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0);
        issue(3'b010, 2'd0, 2'd1, 2'd2, 8'h00, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        // Carry dropped: 0xF0 + 0x20 = 0x10
        issue(3'b001, 2'd1, 2'd0, 2'd0, 8'hF0, 8'h00, 8'h00, 1'b0, 8'hF0, 1'b0);
        issue(3'b001, 2'd2, 2'd0, 2'd0, 8'h20, 8'h00, 8'h00, 1'b0, 8'h20, 1'b0);
        issue(3'b010, 2'd3, 2'd1, 2'd2, 8'h00, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b0);
        // LDI of zero sets the flag, then XOR with the ALU forced to return 0
        issue(3'b001, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        issue(3'b001, 2'd2, 2'd0, 2'd0, 8'h55, 8'h00, 8'h00, 1'b0, 8'h55, 1'b0);
        alu_force_zero = 1'b1;
        issue(3'b100, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 8'h55, 1'b0, 8'h00, 1'b1);
        alu_force_zero = 1'b0;
        // Illegal opcodes: err, r2/r3 untouched, zero_flag held at 1
        issue(3'b110, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h55, 1'b1);
        issue(3'b000, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1);
        // dst == src uses the pre-write value; then XOR 0x55 ^ 0x20
        issue(3'b010, 2'd3, 2'd3, 2'd3, 8'h00, 8'h10, 8'h10, 1'b0, 8'h20, 1'b0);
        issue(3'b100, 2'd1, 2'd2, 2'd3, 8'h00, 8'h55, 8'h20, 1'b0, 8'h75, 1'b0);
        issue(3'b011, 2'd0, 2'd1, 2'd3, 8'h00, 8'h75, 8'h20, 1'b0, 8'h20, 1'b0);
        drain();

        // instr_valid held for 6 cycles with ADD r0,r1,r2 (0x75 + 0x55 = 0xCA)
        accepted = 0;
        instr_op = 3'b010; instr_dst = 2'd0; instr_src1 = 2'd1; instr_src2 = 2'd2;
        @(negedge clk);
        instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            rdy = instr_ready;
            chk("hold_ready", {31'h0, rdy}, {31'h0, ready_pat[5-i]});
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted++;
                e.err = 1'b0; e.dst = 2'd0; e.val = 8'hCA; e.zf = 1'b0; e.lat = 2; e.acc = cyc;
                sb.push_back(e);
            end
        end
        instr_valid = 1'b0;
        chk("hold_accepted", accepted, 32'd2);
        drain();

        // Reset during EXEC: aborted, no done, everything cleared
        @(negedge clk);
        instr_op = 3'b010; instr_dst = 2'd3; instr_src1 = 2'd1; instr_src2 = 2'd2;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec_rs1", {24'h0, alu_rs1}, 32'h75);
        rst_n = 1'b0;
        #1;
        chk("abort_no_done", {30'h0, done, err}, 32'd0);
        chk("abort_alu_quiet", {13'h0, alu_rs1, alu_rs2, alu_opcode}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", {31'h0, instr_ready}, 32'd1);
        chk("abort_zero_flag", {31'h0, zero_flag}, 32'd0);
        check_rf_zero("abort_rf");
        repeat (3) @(negedge clk);

        // Normal operation after reset
        issue(3'b001, 2'd0, 2'd0, 2'd0, 8'h0A, 8'h00, 8'h00, 1'b0, 8'h0A, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
